// File: rtl/fir_pkg.sv
// Shared types and default constants for the FIR filter control block and its
// downstream stages.
package fir_pkg;

    localparam int SAMPLE_W      = 16;
    localparam int FIR_LATENCY   = 3;
    localparam int FIR_DECIM     = 4;
    localparam int FIR_BUF_DEPTH = 8;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// Synchronous FIFO with a registered head word; a word written into an empty
// FIFO appears on o_rdata one cycle after the push edge (no fall-through).
module fir_sync_fifo
    import fir_pkg::*;
#(
    parameter int DEPTH = FIR_BUF_DEPTH
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic [SAMPLE_W-1:0]      i_wdata,
    input  logic                     i_pop,
    output logic [SAMPLE_W-1:0]      o_rdata,
    output logic                     o_empty,
    output logic                     o_accept,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [SAMPLE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]       rd_next;
    logic [LW-1:0]       level_q, level_d;
    logic [SAMPLE_W-1:0] head_q, head_d;
    logic                empty;
    logic                full;
    logic                pop_en;
    logic                accept;

    always_comb begin
        empty   = (level_q == LW'(0));
        full    = (level_q == LW'(DEPTH));
        pop_en  = i_pop && !empty;
        // A full FIFO still takes a word when the head leaves in the same cycle.
        accept  = i_push && (!full || pop_en);
        rd_next = rd_ptr_q + AW'(1);

        wr_ptr_d = accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_en ? rd_next : rd_ptr_q;

        level_d = level_q;
        unique case ({accept, pop_en})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // The incoming word bypasses memory when it becomes the new head.
        head_d = head_q;
        if (accept && (empty || (pop_en && level_q == LW'(1)))) begin
            head_d = i_wdata;
        end else if (pop_en && level_q > LW'(1)) begin
            head_d = mem_q[rd_next];
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
        end
    end

    assign o_rdata  = head_q;
    assign o_empty  = empty;
    assign o_accept = accept;
    assign o_level  = level_q;

endmodule

// File: rtl/fir_decim_buffer.sv
// Realigns filter results to the sample strobe, decimates by DECIM and buffers
// kept results for a valid/ready consumer. Define FIR_BUF_OVF_EN for the sticky overflow flag.
module fir_decim_buffer
    import fir_pkg::*;
#(
    parameter int LATENCY = FIR_LATENCY,
    parameter int DECIM   = FIR_DECIM,
    parameter int DEPTH   = FIR_BUF_DEPTH
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_ce,
    input  logic [15:0]            i_result,
    output logic [15:0]            o_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_overflow,
    input  logic                   i_ovf_clr
);

    localparam int DCNT_W = cnt_width(DECIM);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DECIM - 1);

    logic [LATENCY-1:0] ce_pipe_q, ce_pipe_d;
    logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
    logic               cap;
    logic               keep;
    logic               push_accept;
    logic               fifo_empty;
    sample_t            fifo_rdata;

    always_comb begin
        ce_pipe_d = LATENCY'({ce_pipe_q, i_ce});
        cap       = ce_pipe_q[LATENCY-1];
        keep      = cap && (dcnt_q == DCNT_LAST);

        dcnt_d = dcnt_q;
        if (cap) begin
            dcnt_d = keep ? '0 : dcnt_q + DCNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            ce_pipe_q <= '0;
            dcnt_q    <= '0;
        end else begin
            ce_pipe_q <= ce_pipe_d;
            dcnt_q    <= dcnt_d;
        end
    end

    fir_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_push   (keep),
        .i_wdata  (i_result),
        .i_pop    (i_ready),
        .o_rdata  (fifo_rdata),
        .o_empty  (fifo_empty),
        .o_accept (push_accept),
        .o_level  (o_level)
    );

    assign o_data  = fifo_rdata;
    assign o_valid = !fifo_empty;

`ifdef FIR_BUF_OVF_EN
    logic ovf_q, ovf_d;

    // A drop in the same cycle as a clear request keeps the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (keep && !push_accept) begin
            ovf_d = 1'b1;
        end else if (i_ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign o_overflow = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = &{1'b0, i_ovf_clr, push_accept};
    assign o_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_fir_decim_buffer.sv
// Randomised bench for fir_decim_buffer against a queue-based reference model,
// plus a full-rate DECIM=1 instance fed a ramp.
module tb_fir_decim_buffer;

    localparam int LAT = 3;
    localparam int DEC = 4;
    localparam int DEP = 8;

    logic        clk;
    logic        rst_n;
    logic        ce;
    logic [15:0] res;
    logic        rdy;
    logic        clr;
    logic [15:0] o_data;
    logic        o_valid;
    logic [3:0]  o_level;
    logic        o_ovf;

    logic        rst1_n;
    logic        ce1;
    logic [15:0] res1;
    logic        rdy1;
    logic [15:0] o_data1;
    logic        o_valid1;
    logic [2:0]  o_level1;
    logic        o_ovf1;

    int total = 0;
    int bad   = 0;

    // reference model state
    int          pend[$];
    logic [15:0] mq[$];
    int          capcnt = 0;
    bit          movf   = 0;
    int          cyc    = 0;
    int          xfers  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fir_decim_buffer #(.LATENCY(LAT), .DECIM(DEC), .DEPTH(DEP)) dut (
        .i_clk      (clk),
        .i_reset    (rst_n),
        .i_ce       (ce),
        .i_result   (res),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (rdy),
        .o_level    (o_level),
        .o_overflow (o_ovf),
        .i_ovf_clr  (clr)
    );

    fir_decim_buffer #(.LATENCY(1), .DECIM(1), .DEPTH(4)) dut1 (
        .i_clk      (clk),
        .i_reset    (rst1_n),
        .i_ce       (ce1),
        .i_result   (res1),
        .o_data     (o_data1),
        .o_valid    (o_valid1),
        .i_ready    (rdy1),
        .o_level    (o_level1),
        .o_overflow (o_ovf1),
        .i_ovf_clr  (1'b0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Applies the rules at one rising edge using the inputs held across it.
    task automatic model_edge();
        bit cap;
        bit keep;
        bit drop;
        cap  = (pend.size() > 0) && (pend[0] == cyc);
        if (cap) void'(pend.pop_front());
        if (ce) pend.push_back(cyc + LAT);
        keep = 0;
        if (cap) begin
            capcnt++;
            keep = (capcnt % DEC) == 0;
        end
        if (mq.size() > 0 && rdy) begin
            xfers++;
            $display("xfer %0d: data=%h", xfers, mq[0]);
            void'(mq.pop_front());
        end
        drop = 0;
        if (keep) begin
            if (mq.size() < DEP) mq.push_back(res);
            else drop = 1;
        end
`ifdef FIR_BUF_OVF_EN
        if (drop) movf = 1;
        else if (clr) movf = 0;
`else
        if (drop) movf = 0;
`endif
        cyc++;
    endtask

    task automatic compare();
        check("valid", {31'd0, o_valid}, {31'd0, mq.size() > 0});
        check("level", {28'd0, o_level}, mq.size());
        if (mq.size() > 0) check("data", {16'd0, o_data}, {16'd0, mq[0]});
        check("ovf", {31'd0, o_ovf}, {31'd0, movf});
    endtask

    task automatic step(input bit c, input bit r, input bit k, input logic [15:0] v);
        ce  = c;
        rdy = r;
        clr = k;
        res = v;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        pend.delete();
        mq.delete();
        capcnt = 0;
        movf   = 0;
        for (int i = 0; i < n; i++) begin
            ce  = 1'($urandom);
            res = 16'($urandom);
            rdy = 1'($urandom);
            @(posedge clk);
            cyc++;
            @(negedge clk);
            check("rst_valid", {31'd0, o_valid}, 32'd0);
            check("rst_level", {28'd0, o_level}, 32'd0);
            check("rst_data",  {16'd0, o_data},  32'd0);
            check("rst_ovf",   {31'd0, o_ovf},   32'd0);
        end
        ce    = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        int exp1;
        rst_n  = 1'b0;
        rst1_n = 1'b0;
        ce = 0; rdy = 0; clr = 0; res = '0;
        ce1 = 0; rdy1 = 1; res1 = '0;
        @(negedge clk);
        do_reset(4);
        rst1_n = 1'b1;

        // every 4th strobe kept; result = strobe index when captured
        for (int k = 0; k < 48; k++) begin
            logic [15:0] v;
            v = (k >= LAT && ((k - LAT) % 4) == 0) ? 16'((k - LAT) / 4 + 1) : 16'($urandom);
            step(k % 4 == 0, 1'b1, 1'b0, v);
        end

        // fill past full without a consumer
        for (int k = 0; k < 40; k++) step(1'b1, 1'b0, 1'b0, 16'hA000 + 16'(k));
        // kept pushes while full and draining
        for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 1'b0, 16'h7FFF);
        // refill, then clear requests racing new drops
        for (int k = 0; k < 40; k++) step(1'b1, 1'b0, 1'b0, 16'($urandom));
        for (int k = 0; k < 12; k++) step(1'b1, 1'b0, 1'b1, 16'($urandom));
        step(1'b0, 1'b0, 1'b1, 16'($urandom));
        step(1'b0, 1'b0, 1'b0, 16'($urandom));
        for (int k = 0; k < 12; k++) step(1'b0, 1'b1, 1'b0, 16'($urandom));

        for (int k = 0; k < 600; k++)
            step(1'($urandom), ($urandom % 3) != 0, ($urandom % 8) == 0, 16'($urandom));

        // reset with two strobes in flight: nothing may appear afterwards
        step(1'b1, 1'b0, 1'b0, 16'($urandom));
        step(1'b1, 1'b0, 1'b0, 16'($urandom));
        do_reset(2);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 1'b0, 16'($urandom));
        check("post_rst_level", {28'd0, o_level}, 32'd0);

        for (int k = 0; k < 300; k++)
            step(($urandom % 4) == 0, ($urandom % 2) != 0, ($urandom % 16) == 0, 16'($urandom));

        // DECIM=1 full-rate ramp through the second instance
        exp1 = 0;
        for (int k = 0; k < 22; k++) begin
            ce1  = (k < 16);
            res1 = 16'(k - 1);
            @(posedge clk);
            @(negedge clk);
            check("d1_level_le1", {31'd0, o_level1 <= 3'd1}, 32'd1);
            if (o_valid1) begin
                $display("xfer d1: data=%h", o_data1);
                check("d1_data", {16'd0, o_data1}, exp1);
                exp1++;
            end
        end
        check("d1_count", exp1, 32'd16);
        check("d1_ovf", {31'd0, o_ovf1}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
